// File: rtl/mmu_pkg.sv
// Shared definitions for the Sv39-style page-table walker: PTE bit layout,
// walker state encoding, address-field widths and VPN extraction.
package mmu_pkg;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;

    localparam int VPN_W = 9;
    localparam int PPN_W = 44;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } walk_state_e;

    // VPN field of the virtual address indexing the table at the given level.
    function automatic logic [VPN_W-1:0] vpn_of(input logic [63:0] va, input logic [1:0] level);
        logic [VPN_W-1:0] vpn;
        case (level)
            2'd2:    vpn = va[38:30];
            2'd1:    vpn = va[29:21];
            default: vpn = va[20:12];
        endcase
        return vpn;
    endfunction

endpackage

// File: rtl/pte_decode.sv
// Combinational PTE classifier: validity, leaf detection, superpage
// alignment check and PPN extraction for the current walk level.
module pte_decode
    import mmu_pkg::*;
(
    input  logic [63:0]      pte,
    input  logic [1:0]       level,
    output logic             is_invalid,
    output logic             is_leaf,
    output logic             is_misaligned,
    output logic [PPN_W-1:0] ppn
);

    logic unused_bits;

    assign unused_bits = ^{pte[63:54], pte[9:8], pte[6:4]};
    assign ppn         = pte[PTE_PPN_MSB:PTE_PPN_LSB];
    assign is_leaf     = pte[PTE_R] | pte[PTE_X];
    assign is_invalid  = ~pte[PTE_V] | (~pte[PTE_R] & pte[PTE_W]);

    // A superpage leaf must have its low PPN bits clear at its level.
    always_comb begin
        is_misaligned = 1'b0;
        case (level)
            2'd2:    is_misaligned = is_leaf & (ppn[17:0] != 18'd0);
            2'd1:    is_misaligned = is_leaf & (ppn[8:0] != 9'd0);
            default: is_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/page_table_walker.sv
// Three-level hardware page-table walker: issues PTE reads, descends pointer
// entries, and produces a 4 KiB TLB fill or a page-fault pulse.
module page_table_walker
    import mmu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      va,
    input  logic [PPN_W-1:0] satp_ppn,
    input  logic             abort,
    output logic             mem_req,
    output logic [63:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [63:0]      mem_data,
    output logic             busy,
    output logic             fault,
    output logic             replace,
    output logic [63:0]      replace_va,
    output logic [63:0]      replace_pa,
    output logic             replace_dirty,
    output logic             replace_readable,
    output logic             replace_writable
);

    walk_state_e      state, state_next;
    logic [1:0]       level, level_next;
    logic [63:0]      addr_next;
    logic [63:0]      va_r;
    logic [63:0]      fill_pa;
    logic             load_fill;
    logic             is_invalid, is_leaf, is_misaligned;
    logic [PPN_W-1:0] ppn;

    pte_decode u_pte_decode (
        .pte           (mem_data),
        .level         (level),
        .is_invalid    (is_invalid),
        .is_leaf       (is_leaf),
        .is_misaligned (is_misaligned),
        .ppn           (ppn)
    );

    // Superpage leaves are split into the 4 KiB page containing the VA.
    always_comb begin
        fill_pa = 64'd0;
        case (level)
            2'd2:    fill_pa = {8'd0, ppn[43:18], va_r[29:12], 12'd0};
            2'd1:    fill_pa = {8'd0, ppn[43:9], va_r[20:12], 12'd0};
            default: fill_pa = {8'd0, ppn, 12'd0};
        endcase
    end

    // Next-state, next-level and next-address logic for the walk.
    always_comb begin
        state_next = state;
        level_next = level;
        addr_next  = mem_addr;
        load_fill  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    level_next = 2'd2;
                    addr_next  = {8'd0, satp_ppn, va[38:30], 3'b000};
                end else begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_next = mem_ack ? IDLE : DRAIN;
                end else if (!mem_ack) begin
                    state_next = WAIT;
                end else if (is_invalid) begin
                    state_next = FAULT;
                end else if (is_leaf) begin
                    state_next = is_misaligned ? FAULT : DONE;
                    load_fill  = ~is_misaligned;
                end else if (level == 2'd0) begin
                    state_next = FAULT;
                end else begin
                    state_next = REQ;
                    level_next = level - 2'd1;
                    addr_next  = {8'd0, ppn, vpn_of(va_r, level - 2'd1), 3'b000};
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Walk state, level, request address and sampled VA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            level    <= 2'd2;
            mem_addr <= 64'd0;
            va_r     <= 64'd0;
        end else begin
            state    <= state_next;
            level    <= level_next;
            mem_addr <= addr_next;
            if (state == IDLE && start) begin
                va_r <= va;
            end
        end
    end

    // Fill record captured when a valid aligned leaf arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replace_va       <= 64'd0;
            replace_pa       <= 64'd0;
            replace_dirty    <= 1'b0;
            replace_readable <= 1'b0;
            replace_writable <= 1'b0;
        end else if (load_fill) begin
            replace_va       <= va_r;
            replace_pa       <= fill_pa;
            replace_dirty    <= mem_data[PTE_D];
            replace_readable <= mem_data[PTE_R];
            replace_writable <= mem_data[PTE_W];
        end
    end

    // Pulses are gated by abort so a flush in DONE/FAULT cancels them.
    assign mem_req = (state == REQ) || (state == WAIT);
    assign busy    = (state != IDLE);
    assign replace = (state == DONE) && !abort;
    assign fault   = (state == FAULT) && !abort;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker with hand-computed PTE addresses,
// fill results, fault/abort/reset scenarios.
module tb_page_table_walker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] va = 64'd0;
    logic [43:0] satp_ppn = 44'd0;
    logic        abort = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_data = 64'd0;
    logic        busy, fault, replace;
    logic [63:0] replace_va, replace_pa;
    logic        replace_dirty, replace_readable, replace_writable;

    int vectors = 0;
    int miscompares = 0;
    int replace_cnt = 0;
    int fault_cnt = 0;
    int rc0 = 0;
    int fc0 = 0;

    page_table_walker dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .va               (va),
        .satp_ppn         (satp_ppn),
        .abort            (abort),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_data         (mem_data),
        .busy             (busy),
        .fault            (fault),
        .replace          (replace),
        .replace_va       (replace_va),
        .replace_pa       (replace_pa),
        .replace_dirty    (replace_dirty),
        .replace_readable (replace_readable),
        .replace_writable (replace_writable)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (replace === 1'b1) replace_cnt++;
        if (fault === 1'b1) fault_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_pa", replace_pa, 64'd0);
        reset = 1'b0;
        tick();

        // 3-level walk: pointer -> pointer -> leaf 0x200000CF
        va = 64'h12345678; satp_ppn = 44'h80000; start = 1'b1;
        tick();                               // cycle 1: REQ
        start = 1'b0;
        chk("w3_busy", {63'd0, busy}, 64'd1);
        chk("w3_req1", {63'd0, mem_req}, 64'd1);
        chk("w3_addr2", mem_addr, 64'h80000000);
        tick();                               // cycle 2: WAIT
        mem_ack = 1'b1; mem_data = 64'h20000401;
        tick();                               // cycle 3: REQ
        mem_ack = 1'b0;
        chk("w3_addr1", mem_addr, 64'h80001488);
        tick();                               // cycle 4: WAIT
        mem_ack = 1'b1; mem_data = 64'h20000801;
        tick();                               // cycle 5: REQ
        mem_ack = 1'b0;
        chk("w3_addr0", mem_addr, 64'h80002A28);
        chk("w3_norep", {63'd0, replace}, 64'd0);
        tick();                               // cycle 6: WAIT
        mem_ack = 1'b1; mem_data = 64'h200000CF;
        tick();                               // cycle 7: DONE
        mem_ack = 1'b0;
        #1;
        chk("w3_replace", {63'd0, replace}, 64'd1);
        chk("w3_pa", replace_pa, 64'h80000000);
        chk("w3_va", replace_va, 64'h12345678);
        chk("w3_rdw", {61'd0, replace_readable, replace_dirty, replace_writable}, 64'd7);
        chk("w3_reqlow", {63'd0, mem_req}, 64'd0);
        tick();
        chk("w3_idle", {62'd0, busy, replace}, 64'd0);

        // Level-2 superpage leaf
        rc0 = replace_cnt;
        va = 64'h40201000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("sp_addr", mem_addr, 64'h80000008);
        tick();
        mem_ack = 1'b1; mem_data = 64'h2000000F;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("sp_replace", {63'd0, replace}, 64'd1);
        chk("sp_pa", replace_pa, 64'h80201000);
        chk("sp_flags", {61'd0, replace_readable, replace_dirty, replace_writable}, 64'd5);
        tick();
        chk("sp_onepulse", 64'(replace_cnt - rc0), 64'd1);

        // Level-1 PTE of zero faults; WAIT holds address until ack
        rc0 = replace_cnt; fc0 = fault_cnt;
        va = 64'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("hold_req", {63'd0, mem_req}, 64'd1);
        chk("hold_addr", mem_addr, 64'h80000000);
        mem_ack = 1'b1; mem_data = 64'h20000401;
        tick();
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1; mem_data = 64'd0;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("z_fault", {63'd0, fault}, 64'd1);
        chk("z_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("z_busy_low", {63'd0, busy}, 64'd0);
        chk("z_fault_once", 64'(fault_cnt - fc0), 64'd1);
        chk("z_no_rep", 64'(replace_cnt - rc0), 64'd0);

        // Misaligned level-1 leaf (PPN 0x80001) faults
        rc0 = replace_cnt; fc0 = fault_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ack = 1'b1; mem_data = 64'h20000401;
        tick();
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1; mem_data = 64'h2000040F;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("mis_fault", 64'(fault_cnt - fc0), 64'd1);
        chk("mis_no_rep", 64'(replace_cnt - rc0), 64'd0);

        // Abort two cycles into WAIT; DRAIN absorbs a late ack, ignores start
        rc0 = replace_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("dr_req_low", {63'd0, mem_req}, 64'd0);
        chk("dr_busy", {63'd0, busy}, 64'd1);
        va = 64'h40201000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dr_start_ign", {62'd0, busy, mem_req}, 64'd2);
        tick();
        tick();
        tick();
        mem_ack = 1'b1; mem_data = 64'h200000CF;
        tick();
        mem_ack = 1'b0;
        chk("dr_idle", {62'd0, busy, mem_req}, 64'd0);
        tick();
        chk("dr_still_idle", {63'd0, busy}, 64'd0);
        chk("dr_no_rep", 64'(replace_cnt - rc0), 64'd0);

        // Abort in REQ returns straight to IDLE
        start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_req_idle", {63'd0, busy}, 64'd0);

        // Abort coinciding with ack discards the data
        rc0 = replace_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1; mem_ack = 1'b1; mem_data = 64'h2000000F;
        tick();
        abort = 1'b0; mem_ack = 1'b0;
        chk("ab_ack_idle", {63'd0, busy}, 64'd0);
        tick();
        chk("ab_ack_norep", 64'(replace_cnt - rc0), 64'd0);

        // Abort in DONE suppresses the replace pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ack = 1'b1; mem_data = 64'h2000000F;
        tick();
        mem_ack = 1'b0; abort = 1'b1;
        #1;
        chk("ab_done_norep", {63'd0, replace}, 64'd0);
        tick();
        abort = 1'b0;
        chk("ab_done_idle", {63'd0, busy}, 64'd0);

        // Reset mid-WAIT, then a late ack
        rc0 = replace_cnt;
        va = 64'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mr_outs", {61'd0, busy, mem_req, replace}, 64'd0);
        chk("mr_addr", mem_addr, 64'd0);
        chk("mr_pa", replace_pa, 64'd0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_data = 64'h200000CF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("mr_idle", {62'd0, busy, mem_req}, 64'd0);
        chk("mr_va", replace_va, 64'd0);
        chk("mr_no_rep", 64'(replace_cnt - rc0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
